// File: rtl/yuv2rgb_stream_arbiter_pkg.sv
// yuv2rgb_pkg: shared widths, FSM state type and round-robin pick for the stream arbiter
package yuv2rgb_pkg;
    localparam int PIXEL_W = 24;
    localparam int BEAT_W = 3072;
    localparam int DEF_BEAT_PIXELS = BEAT_W / PIXEL_W;

    typedef enum logic {IDLE, BURST} arb_state_t;

    // First requester after 'last' in circular order; returns 'last' if nobody requests
    function automatic int rr_pick(input logic [7:0] valid, input int last, input int n);
        int pick;
        pick = last;
        for (int k = n; k >= 1; k--)
            if (valid[3'((last + k) % n)]) pick = (last + k) % n;
        return pick;
    endfunction
endpackage

// File: rtl/yuv2rgb_stream_arbiter_if.sv
// yuv2rgb_stream_arbiter_if: per-camera YUV pixel streams with valid/ready handshake
interface yuv2rgb_stream_arbiter_if #(parameter int NUM_CAM = 4);
    logic [NUM_CAM-1:0] req_valid;
    logic [NUM_CAM*yuv2rgb_pkg::PIXEL_W-1:0] req_yuv;
    logic [NUM_CAM-1:0] req_ready;
    modport master (output req_valid, req_yuv, input req_ready);
    modport slave (input req_valid, req_yuv, output req_ready);
endinterface

// File: rtl/yuv2rgb_stream_arbiter_cam_tag_fifo.sv
// cam_tag_fifo: synchronous FIFO holding the camera ID of every beat in flight in the converter
module cam_tag_fifo #(
    parameter int W = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic do_push;
    assign do_push = push && !full;
    assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign empty = wp == rp;
    assign head = mem[rp[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/yuv2rgb_stream_arbiter.sv
// yuv2rgb_stream_arbiter: round-robin, beat-granular sharing of one YUV->RGB converter
module yuv2rgb_stream_arbiter import yuv2rgb_pkg::*; #(
    parameter int NUM_CAM = 4,
    parameter int BEAT_PIXELS = DEF_BEAT_PIXELS,
    parameter int TAG_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    yuv2rgb_stream_arbiter_if.slave    cam,
    output logic [7:0]                 conv_y,
    output logic [7:0]                 conv_u,
    output logic [7:0]                 conv_v,
    output logic                       conv_valid,
    input  logic [BEAT_W-1:0]          conv_data,
    input  logic                       conv_done,
    output logic [BEAT_W-1:0]          out_data,
    output logic                       out_valid,
    output logic [$clog2(NUM_CAM)-1:0] out_cam_id,
    output logic                       busy,
    output logic                       err_orphan
);
    localparam int CAM_W = $clog2(NUM_CAM);
    localparam int CNT_W = $clog2(BEAT_PIXELS);

    arb_state_t state, next_state;
    logic [CAM_W-1:0] grant, last_grant, win, head;
    logic [CNT_W-1:0] pix_cnt;
    logic start, accept, beat_end, pop, full, empty;

    assign win = CAM_W'(rr_pick(8'(cam.req_valid), int'(last_grant), NUM_CAM));
    assign start = state == IDLE && |cam.req_valid && !full;
    assign accept = state == BURST && cam.req_valid[grant];
    assign beat_end = accept && pix_cnt == CNT_W'(BEAT_PIXELS - 1);
    assign pop = conv_done && !empty;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= next_state;

    always_comb
        next_state = start ? BURST : beat_end ? IDLE : state;

    always_comb begin
        cam.req_ready = '0;
        if (state == BURST) cam.req_ready[grant] = 1'b1;
        busy = state != IDLE || !empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant <= '0;
            last_grant <= CAM_W'(NUM_CAM - 1);
            pix_cnt <= '0;
            conv_valid <= 1'b0;
            {conv_y, conv_u, conv_v} <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_cam_id <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (start) begin
                grant <= win;
                last_grant <= win;
                pix_cnt <= '0;
            end else if (accept) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
            conv_valid <= accept;
            if (accept) {conv_y, conv_u, conv_v} <= cam.req_yuv[PIXEL_W*grant +: PIXEL_W];
            // Tag pop and data capture share a cycle so out_cam_id lines up with out_data
            out_valid <= pop;
            if (pop) begin
                out_data <= conv_data;
                out_cam_id <= head;
            end
            if (conv_done && empty) err_orphan <= 1'b1;
        end
    end

    cam_tag_fifo #(.W(CAM_W), .DEPTH(TAG_DEPTH)) u_tags (
        .clk(clk),
        .rst(rst),
        .push(beat_end),
        .pop(pop),
        .din(grant),
        .full(full),
        .empty(empty),
        .head(head)
    );
endmodule

// File: tb/tb_yuv2rgb_stream_arbiter.sv
// tb_yuv2rgb_stream_arbiter: directed scenarios for the converter-sharing arbiter
module tb_yuv2rgb_stream_arbiter;
    import yuv2rgb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] conv_y, conv_u, conv_v;
    logic conv_valid, out_valid, busy, err_orphan;
    logic conv_done = 1'b0;
    logic [BEAT_W-1:0] conv_data = '0;
    logic [BEAT_W-1:0] out_data;
    logic [1:0] out_cam_id;

    yuv2rgb_stream_arbiter_if #(.NUM_CAM(4)) cam();

    yuv2rgb_stream_arbiter #(.NUM_CAM(4), .BEAT_PIXELS(128), .TAG_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .cam(cam),
        .conv_y(conv_y),
        .conv_u(conv_u),
        .conv_v(conv_v),
        .conv_valid(conv_valid),
        .conv_data(conv_data),
        .conv_done(conv_done),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_cam_id(out_cam_id),
        .busy(busy),
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int cnt[4];
    int quota[4];
    logic [3:0] en, prev_rdy;
    logic [1:0] tags[$];
    logic [1:0] grants[$];
    int starts[$];
    int lens[$];
    int burst_acc, gap_cam, gap_at, gap_left;
    logic gap_on, exp_err, auto_done;

    function automatic logic [23:0] pix(input int i, input int k);
        return {8'(8'hA0 + i), 8'(k), 8'(k ^ 8'h5A)};
    endfunction

    function automatic logic [1:0] oh2i(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic upd();
        gap_on = gap_left > 0 && cnt[gap_cam] == gap_at;
        for (int i = 0; i < 4; i++) begin
            cam.req_valid[i] = en[i] && cnt[i] < quota[i] && !(gap_on && i == gap_cam);
            cam.req_yuv[24*i +: 24] = pix(i, cnt[i]);
        end
        if (auto_done) begin
            conv_done = tags.size() > 0;
            for (int w = 0; w < 96; w++) conv_data[32*w +: 32] = $urandom;
        end
    endtask

    // One clock: predicts pixel/return-path results, then checks them just after the edge
    task automatic cycle();
        logic [3:0] acc, rdy;
        logic exp_ov, exp_cv;
        logic [1:0] exp_id;
        logic [BEAT_W-1:0] exp_data;
        logic [23:0] exp_pix;
        rdy = cam.req_ready;
        acc = cam.req_valid & rdy;
        if (rdy != 0 && prev_rdy == 0) begin
            grants.push_back(oh2i(rdy));
            starts.push_back(cyc);
            burst_acc = 0;
        end
        if (rdy == 0 && prev_rdy != 0) lens.push_back(burst_acc);
        prev_rdy = rdy;
        exp_ov = 1'b0;
        exp_id = 2'd0;
        exp_data = '0;
        if (conv_done) begin
            if (tags.size() > 0) begin
                exp_ov = 1'b1;
                exp_id = tags.pop_front();
                exp_data = conv_data;
            end else exp_err = 1'b1;
        end
        exp_cv = acc != 0;
        exp_pix = '0;
        for (int i = 0; i < 4; i++) if (acc[i]) begin
            exp_pix = pix(i, cnt[i]);
            cnt[i]++;
            burst_acc++;
            if (burst_acc == 128) tags.push_back(2'(i));
        end
        @(posedge clk);
        #1;
        cyc++;
        if (gap_on) gap_left--;
        vectors++;
        if (!$onehot0(rdy)) begin errors++; $display("FAIL req_ready_onehot cyc %0d: got %b expected at most one bit", cyc, rdy); end
        vectors++;
        if (conv_valid !== exp_cv) begin errors++; $display("FAIL conv_valid cyc %0d: got %b expected %b", cyc, conv_valid, exp_cv); end
        if (exp_cv) begin
            vectors++;
            if ({conv_y, conv_u, conv_v} !== exp_pix) begin errors++; $display("FAIL conv_yuv cyc %0d: got %h expected %h", cyc, {conv_y, conv_u, conv_v}, exp_pix); end
        end
        vectors++;
        if (out_valid !== exp_ov) begin errors++; $display("FAIL out_valid cyc %0d: got %b expected %b", cyc, out_valid, exp_ov); end
        if (exp_ov) begin
            vectors++;
            if (out_cam_id !== exp_id) begin errors++; $display("FAIL out_cam_id cyc %0d: got %0d expected %0d", cyc, out_cam_id, exp_id); end
            vectors++;
            if (out_data !== exp_data) begin errors++; $display("FAIL out_data cyc %0d: got ..%h expected ..%h", cyc, out_data[63:0], exp_data[63:0]); end
        end
        vectors++;
        if (err_orphan !== exp_err) begin errors++; $display("FAIL err_orphan cyc %0d: got %b expected %b", cyc, err_orphan, exp_err); end
        upd();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = '0;
        conv_done = 1'b0;
        auto_done = 1'b0;
        exp_err = 1'b0;
        prev_rdy = '0;
        burst_acc = 0;
        gap_left = 0;
        gap_cam = 0;
        gap_at = 0;
        for (int i = 0; i < 4; i++) begin cnt[i] = 0; quota[i] = 0; end
        tags.delete();
        grants.delete();
        starts.delete();
        lens.delete();
        upd();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (cam.req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", cam.req_ready); end
        vectors++; if (conv_valid !== 1'b0) begin errors++; $display("FAIL reset_conv_valid: got %b expected 0", conv_valid); end
        vectors++; if ({conv_y, conv_u, conv_v} !== 24'h0) begin errors++; $display("FAIL reset_conv_yuv: got %h expected 0", {conv_y, conv_u, conv_v}); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got ..%h expected 0", out_data[63:0]); end
        vectors++; if (out_cam_id !== 2'd0) begin errors++; $display("FAIL reset_out_cam_id: got %0d expected 0", out_cam_id); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan: got %b expected 0", err_orphan); end
    endtask

    task automatic test_single();
        do_reset();
        en = 4'b0100;
        quota[2] = 128;
        upd();
        for (int k = 0; k < 300 && tags.size() == 0; k++) cycle();
        cycle();
        vectors++; if (grants.size() != 1 || grants[0] != 2'd2) begin errors++; $display("FAIL single_grant: got %0d grants first %0d expected 1 grant of cam 2", grants.size(), grants.size() ? grants[0] : 2'd0); end
        vectors++; if (lens.size() != 1 || lens[0] != 128) begin errors++; $display("FAIL single_len: got %0d expected 128", lens.size() ? lens[0] : -1); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_tag: got %b expected 1", busy); end
        conv_done = 1'b1;
        for (int w = 0; w < 96; w++) conv_data[32*w +: 32] = 32'hC0DE0000 + w;
        cycle();
        conv_done = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_cam_id !== 2'd2) begin errors++; $display("FAIL single_return: got valid %b id %0d expected valid 1 id 2", out_valid, out_cam_id); end
        cycle();
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_drain: got valid %b busy %b expected 0 0", out_valid, busy); end
    endtask

    task automatic test_round_robin();
        do_reset();
        en = 4'b1111;
        quota[0] = 256;
        quota[1] = 128;
        quota[2] = 128;
        quota[3] = 128;
        auto_done = 1'b1;
        upd();
        for (int k = 0; k < 1000 && lens.size() < 5; k++) cycle();
        vectors++; if (lens.size() != 5) begin errors++; $display("FAIL rr_bursts: got %0d expected 5", lens.size()); end
        for (int b = 0; b < 5 && b < grants.size(); b++) begin
            vectors++;
            if (grants[b] != 2'(b % 4)) begin errors++; $display("FAIL rr_grant_%0d: got %0d expected %0d", b, grants[b], b % 4); end
            vectors++;
            if (lens[b] != 128) begin errors++; $display("FAIL rr_len_%0d: got %0d expected 128", b, lens[b]); end
            if (b > 0) begin
                vectors++;
                if (starts[b] - starts[b-1] != 129) begin errors++; $display("FAIL rr_spacing_%0d: got %0d expected 129", b, starts[b] - starts[b-1]); end
            end
        end
    endtask

    task automatic test_gap();
        int low;
        logic seen;
        do_reset();
        en = 4'b0010;
        quota[1] = 128;
        gap_cam = 1;
        gap_at = 50;
        gap_left = 5;
        low = 0;
        seen = 1'b0;
        upd();
        for (int k = 0; k < 300 && cnt[1] < 128; k++) begin
            cycle();
            if (seen && !conv_valid) low++;
            if (conv_valid) seen = 1'b1;
        end
        vectors++; if (cnt[1] != 128) begin errors++; $display("FAIL gap_accepted: got %0d expected 128", cnt[1]); end
        vectors++; if (low != 5) begin errors++; $display("FAIL gap_low_cycles: got %0d expected 5", low); end
        vectors++; if (grants.size() != 1) begin errors++; $display("FAIL gap_grant_held: got %0d grants expected 1", grants.size()); end
        vectors++; if (cam.req_ready !== 4'b0 || busy !== 1'b1) begin errors++; $display("FAIL gap_beat_end: got ready %b busy %b expected 0000 1", cam.req_ready, busy); end
        conv_done = 1'b1;
        cycle();
        conv_done = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_cam_id !== 2'd1) begin errors++; $display("FAIL gap_return: got valid %b id %0d expected valid 1 id 1", out_valid, out_cam_id); end
    endtask

    task automatic test_full();
        logic granted;
        do_reset();
        en = 4'b1111;
        for (int i = 0; i < 4; i++) quota[i] = 128;
        upd();
        for (int k = 0; k < 700 && tags.size() < 4; k++) cycle();
        vectors++; if (tags.size() != 4) begin errors++; $display("FAIL full_tags: got %0d expected 4", tags.size()); end
        quota[0] = 256;
        upd();
        for (int k = 0; k < 6; k++) begin
            cycle();
            vectors++;
            if (cam.req_ready !== 4'b0 || busy !== 1'b1) begin errors++; $display("FAIL full_stall_%0d: got ready %b busy %b expected 0000 1", k, cam.req_ready, busy); end
        end
        conv_done = 1'b1;
        conv_data = '1;
        cycle();
        conv_done = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_cam_id !== 2'd0) begin errors++; $display("FAIL full_pop: got valid %b id %0d expected valid 1 id 0", out_valid, out_cam_id); end
        granted = 1'b0;
        for (int k = 0; k < 2 && !granted; k++) begin
            cycle();
            granted = cam.req_ready == 4'b0001;
        end
        vectors++; if (!granted) begin errors++; $display("FAIL full_regrant: got ready %b expected 0001 within 2 cycles", cam.req_ready); end
    endtask

    task automatic test_orphan();
        do_reset();
        conv_done = 1'b1;
        cycle();
        conv_done = 1'b0;
        cycle();
        cycle();
        vectors++; if (err_orphan !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL orphan_sticky: got err %b valid %b expected 1 0", err_orphan, out_valid); end
        do_reset();
        vectors++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_clear: got %b expected 0", err_orphan); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 4'b1000;
        quota[3] = 128;
        upd();
        for (int k = 0; k < 200 && cnt[3] < 60; k++) cycle();
        vectors++; if (cnt[3] != 60 || grants.size() == 0 || grants[0] != 2'd3) begin errors++; $display("FAIL mid_setup: got %0d pixels expected 60 on cam 3", cnt[3]); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (cam.req_ready !== 4'b0 || conv_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_async: got ready %b conv_valid %b busy %b expected 0000 0 0", cam.req_ready, conv_valid, busy); end
        vectors++; if ({conv_y, conv_u, conv_v} !== 24'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_data: got yuv %h out_valid %b expected 0 0", {conv_y, conv_u, conv_v}, out_valid); end
        do_reset();
        en = 4'b1111;
        for (int i = 0; i < 4; i++) quota[i] = 128;
        upd();
        for (int k = 0; k < 10 && grants.size() == 0; k++) cycle();
        vectors++; if (grants.size() == 0 || grants[0] != 2'd0) begin errors++; $display("FAIL mid_next_grant: got %0d expected cam 0", grants.size() ? grants[0] : 2'd3); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_gap();
        test_full();
        test_orphan();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/yuv2rgb_stream_arbiter.md
# yuv2rgb_stream_arbiter

Shares the single `hw_accelerated_yuv2rgb` converter between `NUM_CAM` camera YUV pixel streams. Arbitration is round-robin at beat granularity: one grant covers exactly `BEAT_PIXELS` pixels, which is one 3072-bit converter output beat. The block feeds the converter through a registered mux and keeps a FIFO of granted camera IDs. It uses that FIFO to tag each RGB beat the converter returns. It sits between the camera decoder front-ends and the converter.

## Interface
- `NUM_CAM`, default 4: number of requesting streams, range 2..8.
- `BEAT_PIXELS`, default 128: pixels per grant; must equal the converter beat size (3072/24).
- `TAG_DEPTH`, default 4: depth of the camera-ID tag FIFO (power of two).
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input NUM_CAM: per-stream pixel valid.
- `req_yuv` input NUM_CAM*24: per-stream {Y,U,V}; stream i occupies bits [24i+23:24i], Y in the MSBs.
- `req_ready` output NUM_CAM: pixel accepted when `req_valid[i] & req_ready[i]`.
- `conv_y`, `conv_u`, `conv_v` output 8 each: to converter `Y`/`U`/`V`.
- `conv_valid` output 1: to converter `valid_in`.
- `conv_data` input 3072: converter `data_out`.
- `conv_done` input 1: converter `valid_out`.
- `out_data` output 3072: tagged RGB beat.
- `out_valid` output 1: one-cycle beat strobe; no backpressure.
- `out_cam_id` output $clog2(NUM_CAM): source stream of `out_data`.
- `busy` output 1: high when the FSM is not IDLE or the tag FIFO is non-empty.
- `err_orphan` output 1: sticky; set by `conv_done` while the tag FIFO is empty.

## Operation
- **FSM states: IDLE, BURST.**
- **IDLE behaviour:**
  - If any `req_valid` is high and the tag FIFO is not full, pick the winner by searching round-robin starting at `last_grant+1` (mod NUM_CAM).
  - Register the winner as `grant`, set `last_grant`, clear `pix_cnt`, and go to BURST.
  - Otherwise stay in IDLE.
- **BURST behaviour:**
  - `req_ready[grant]=1`; all other `req_ready` bits are 0.
  - On acceptance:
    - Register the pixel onto `conv_y/u/v` and set `conv_valid=1` for the next cycle.
    - Increment `pix_cnt`.
  - When `req_valid[grant]` is low, `conv_valid=0` next cycle. Gaps are allowed and the grant is held.
  - On acceptance with `pix_cnt==BEAT_PIXELS-1`:
    - Push `grant` into the tag FIFO.
    - Go to IDLE.
- **Return path:**
  - On `conv_done`:
    - Pop the FIFO head.
    - Next cycle: `out_data<=conv_data`, `out_cam_id<=head`, `out_valid=1`.
  - `conv_done` with an empty FIFO: set `err_orphan`, suppress `out_valid`, leave the FIFO unchanged.
- **Simultaneous push and pop:** both take effect; occupancy is unchanged.
- **Full FIFO:** a push never occurs when full, because IDLE does not grant while full.
- **Not supported:** a stream cannot abandon a burst. Back-to-back bursts by the same camera are allowed when it is the only requester.

## Timing
- **Reset values:**
  - FSM=IDLE, `grant=0`, `last_grant=NUM_CAM-1` (so camera 0 wins first), `pix_cnt=0`.
  - FIFO empty.
  - `req_ready=0`, `conv_valid=0`, `conv_y/u/v=0`.
  - `out_valid=0`, `out_data=0`, `out_cam_id=0`.
  - `busy=0`, `err_orphan=0`.
- **Arbitration:** 1 cycle (IDLE) between bursts. `req_ready` rises the cycle after the IDLE decision.
- **Pixel path:** pixel accepted at cycle t; `conv_valid` and data are presented at t+1.
- **Return path:** `conv_done` at cycle t; `out_valid` and `out_cam_id` at t+1.
- **Reset mid-burst:** the partial beat is discarded and tags are lost. The converter shares `rst`, so its formatter clears too; no orphan results.
- **`err_orphan`:** cleared only by `rst`.

## Structure
- **Package `yuv2rgb_pkg`:**
  - `PIXEL_W=24` and `BEAT_W=3072`.
  - `BEAT_PIXELS` default.
  - `arb_state_t` enum {IDLE, BURST}.
- **Sub-module `cam_tag_fifo`:**
  - Synchronous FIFO, width $clog2(NUM_CAM), depth TAG_DEPTH.
  - Ports: push, pop, full, empty, head.
- Round-robin pick is a function in the package.

## Test plan
- **Single requester:** cam 2 streams 128 pixels with no gaps.
  - `req_ready[2]` is high for 128 accepted cycles.
  - Model converter `conv_done` → `out_valid` one cycle later with `out_cam_id=2`.
- **All four requesting continuously:**
  - Grants go 0,1,2,3,0.
  - Each burst is exactly 128 pixels.
  - One IDLE cycle occurs between bursts.
- **Gapped burst:** cam 1 drops `req_valid` for 5 cycles mid-burst.
  - Grant is held.
  - `conv_valid` is low for exactly those 5 cycles.
  - Push occurs on the 128th accepted pixel.
- **Stall on full tags:** converter `conv_done` is withheld after 4 bursts.
  - FSM stays in IDLE with `req_ready=0`.
  - One `conv_done` → the next grant follows within 2 cycles.
- **Orphan:** `conv_done` pulsed after reset with no burst.
  - `err_orphan=1` and `out_valid` stays 0.
  - `rst` clears `err_orphan`.
- **Reset mid-burst:** `rst` asserted at pixel 60 of a cam 3 burst.
  - All outputs return to reset values asynchronously.
  - The next grant goes to cam 0.
